clm_red_demap: RTL

- Downstream stage of the CLM multiplier. Consumes the multiplier's 16-bit redundant product on its drdy_o pulse.
- Reduces the product modulo the AES field polynomial (x^8+x^4+x^3+x+1) with a bit-serial sequential reducer, then removes an 8-bit additive mask.
- Emits the 8-bit GF(2^8) result with a one-cycle ready pulse, feeding the S-box/output stage.

---
 rtl/clm_red_demap_pkg.sv | 25 ++
 rtl/clm_red_step.sv | 46 ++++
 rtl/clm_red_demap.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/clm_red_demap_pkg.sv
// -----------------------------------------------------------------------------
// clm_red_demap_pkg
// Shared types and constants for the CLM redundant-product demapper:
// GF(2^8) element type, AES reduction polynomial, FSM state encoding and
// a helper that sizes the step counter.
// -----------------------------------------------------------------------------
package clm_red_demap_pkg;

  // Reduction polynomial is OUT_W+1 bits wide; for the AES field that is 9 bits.
  typedef logic [8:0] red_poly_t;
  typedef logic [7:0] field_t;

  localparam red_poly_t AES_POLY = 9'h11B;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REDUCE = 1'b1
  } state_t;

  // Width of a counter that must hold 0 .. l-1 (at least one bit).
  function automatic int cnt_width(input int l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction

endpackage

// File: rtl/clm_red_step.sv
// -----------------------------------------------------------------------------
// clm_red_step
// Combinational reduction step: clears BPC bits of the work register, walking
// from bit IN_W-1-i_cnt*BPC downward. Whenever the bit under inspection is set,
// RED_POLY aligned so its MSB sits on that bit is XORed in (carry-less).
//
// Ports:
//   i_acc  IN_W   current work register
//   i_cnt  CNT_W  index of the step being performed
//   o_acc  IN_W   work register after this step
// -----------------------------------------------------------------------------
module clm_red_step
  import clm_red_demap_pkg::*;
#(
  parameter int               IN_W     = 16,
  parameter int               OUT_W    = 8,
  parameter logic [OUT_W:0]   RED_POLY = AES_POLY,
  parameter int               BPC      = 1,
  parameter int               CNT_W    = 3
) (
  input  logic [IN_W-1:0]  i_acc,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [IN_W-1:0]  o_acc
);

  localparam logic [IN_W-1:0] TOP_BIT = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] POLY_EXT = {{(IN_W-OUT_W-1){1'b0}}, RED_POLY};

  logic [IN_W-1:0] w_acc;

  // NOTE: every variable written in an always_comb gets a default at the top,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    w_acc = i_acc;
    for (int j = 0; j < BPC; j++) begin
      // Bit under inspection sits sh places below the MSB; the polynomial MSB
      // is shifted onto that same bit, which cancels it.
      if (|(w_acc & (TOP_BIT >> (int'(i_cnt) * BPC + j)))) begin
        w_acc = w_acc ^ (POLY_EXT << (IN_W - 1 - OUT_W - int'(i_cnt) * BPC - j));
      end
    end
  end

  assign o_acc = w_acc;

endmodule

// File: rtl/clm_red_demap.sv
// -----------------------------------------------------------------------------
// clm_red_demap
// Downstream stage of the CLM multiplier. Captures the redundant product and
// an additive mask on drdy_i, reduces the product modulo RED_POLY in exactly
// L=(IN_W-OUT_W)/BPC cycles (constant time, no early exit), removes the mask
// and emits the field element with a one-cycle drdy_o pulse.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   drdy_i     input valid, only honoured in IDLE
//   p_i        IN_W   redundant product
//   mask_i     OUT_W  additive mask, captured with p_i
//   out_o      OUT_W  reduced, unmasked result, held until next completion
//   drdy_o     one-cycle pulse, out_o valid
//   busy_o     high while reducing
//   zero_o     out_o == 0, updated with out_o
//   overrun_o  sticky: drdy_i seen while busy (cleared by reset only)
// -----------------------------------------------------------------------------
module clm_red_demap
  import clm_red_demap_pkg::*;
#(
  parameter int             IN_W     = 16,
  parameter int             OUT_W    = 8,
  parameter logic [OUT_W:0] RED_POLY = AES_POLY,
  parameter int             BPC      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drdy_i,
  input  logic [IN_W-1:0]  p_i,
  input  logic [OUT_W-1:0] mask_i,
  output logic [OUT_W-1:0] out_o,
  output logic             drdy_o,
  output logic             busy_o,
  output logic             zero_o,
  output logic             overrun_o
);

  localparam int L     = (IN_W - OUT_W) / BPC;
  localparam int CNT_W = cnt_width(L);

  if (BPC < 1 || ((IN_W - OUT_W) % BPC) != 0) begin : g_bpc_check
    $error("clm_red_demap: BPC must divide IN_W-OUT_W");
  end
  if (RED_POLY[OUT_W] != 1'b1) begin : g_poly_check
    $error("clm_red_demap: RED_POLY MSB must be set");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [IN_W-1:0]  r_acc;
  logic [IN_W-1:0]  w_acc_next;
  logic [OUT_W-1:0] r_mask;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_result;
  logic             r_drdy;
  logic             r_busy;
  logic             r_zero;
  logic             r_overrun;
  logic             w_accept;
  logic             w_last;

  clm_red_step #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .RED_POLY (RED_POLY),
    .BPC      (BPC),
    .CNT_W    (CNT_W)
  ) u_step (
    .i_acc (r_acc),
    .i_cnt (r_cnt),
    .o_acc (w_acc_next)
  );

  assign w_result = w_acc_next[OUT_W-1:0] ^ r_mask;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (drdy_i) begin
          w_accept     = 1'b1;
          w_state_next = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (r_cnt == CNT_W'(L - 1)) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mask    <= '0;
      r_out     <= '0;
      r_drdy    <= 1'b0;
      r_busy    <= 1'b0;
      r_zero    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_REDUCE);
      r_drdy  <= w_last;

      if (w_accept) begin
        r_acc  <= p_i;
        r_mask <= mask_i;
        r_cnt  <= '0;
      end else if (r_state == ST_REDUCE) begin
        r_acc <= w_acc_next;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end

      if (w_last) begin
        r_out  <= w_result;
        r_zero <= (w_result == '0);
      end

      // A request arriving mid-reduction is dropped but remembered.
      if (r_state == ST_REDUCE && drdy_i) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign out_o     = r_out;
  assign drdy_o    = r_drdy;
  assign busy_o    = r_busy;
  assign zero_o    = r_zero;
  assign overrun_o = r_overrun;

endmodule
